// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin arbiter feeding bytes from NUM_REQ requesters into one UART transmitter.
// Latency : request in IDLE at cycle n -> o_Tx_DV/o_Req_Ack/o_Tx_Byte in cycle n+1; i_Tx_Done in WAIT -> o_Req_Done next cycle.
// Backpressure: no grant while i_Tx_Active is high or a transfer is in flight; requests are levels and are not remembered.
//
// Ports:
//   i_Clock, i_Reset (synchronous, active-high)
//   i_Req_DV[k], i_Req_Byte[8k+7:8k]  : requester k valid level and data
//   o_Req_Ack[k], o_Req_Done[k]       : one-cycle capture / completion pulses
//   o_Tx_DV, o_Tx_Byte                : start pulse and held byte to the transmitter
//   i_Tx_Active, i_Tx_Done            : transmitter busy level and completion pulse
//   o_Busy, o_Grant_Id, o_Timeout     : status
// Optional: define UART_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CLKS cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic [NUM_REQ-1:0]         i_Req_DV,
    input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
    output logic [NUM_REQ-1:0]         o_Req_Ack,
    output logic [NUM_REQ-1:0]         o_Req_Done,
    output logic                       o_Tx_DV,
    output logic [7:0]                 o_Tx_Byte,
    input  logic                       i_Tx_Active,
    input  logic                       i_Tx_Done,
    output logic                       o_Busy,
    output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
    output logic                       o_Timeout
);

    localparam int GW = $clog2(NUM_REQ);

    // Elaboration-time guard on the supported parameter range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CLKS < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CLKS >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;      // first index examined by the next search
    logic [GW-1:0]      grant_q, grant_d;
    logic [7:0]         byte_q, byte_d;
    logic               tx_dv_q, tx_dv_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // Round-robin search: walk NUM_REQ positions starting at ptr_q, wrapping
    // modulo NUM_REQ (also correct when NUM_REQ is not a power of two).
    logic          req_found;
    logic [GW-1:0] req_sel;
    logic [GW:0]   cand;

    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (GW+1)'(i);
            if (cand >= (GW+1)'(NUM_REQ)) begin
                cand = cand - (GW+1)'(NUM_REQ);
            end
            if (!req_found && i_Req_DV[cand[GW-1:0]]) begin
                req_found = 1'b1;
                req_sel   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        byte_d  = byte_q;
        tx_dv_d = 1'b0;
        ack_d   = '0;
        done_d  = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // The transmitter has no reset, so it may still be mid-frame.
                if (req_found && !i_Tx_Active) begin
                    state_d = ST_SEND;
                    tx_dv_d = 1'b1;
                    ack_d   = NUM_REQ'(1) << req_sel;
                    grant_d = req_sel;
                    byte_d  = i_Req_Byte[{req_sel, 3'b000} +: 8];
                    ptr_d   = (req_sel == GW'(NUM_REQ - 1)) ? '0 : req_sel + GW'(1);
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (i_Tx_Done) begin
                    state_d = ST_IDLE;
                    done_d  = NUM_REQ'(1) << grant_q;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CLKS)) begin
                    // Give up on a transmitter that never reports completion.
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            byte_q  <= '0;
            tx_dv_q <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            tx_dv_q <= tx_dv_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign o_Timeout = timeout_q;
`else
    assign o_Timeout = 1'b0;
`endif

    assign o_Req_Ack  = ack_q;
    assign o_Req_Done = done_q;
    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = byte_q;
    assign o_Grant_Id = grant_q;
    assign o_Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CLKS=16).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: transmitter Active/Done modelled directly from the stimulus.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [3:0]  dv    = '0;
    logic [31:0] bytes = '0;
    logic        act   = 1'b0;
    logic        done  = 1'b0;

    logic [3:0]  ack;
    logic [3:0]  rdone;
    logic        txdv;
    logic [7:0]  txb;
    logic        busy;
    logic [1:0]  gid;
    logic        tmo;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(TO)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_DV    (dv),
        .i_Req_Byte  (bytes),
        .o_Req_Ack   (ack),
        .o_Req_Done  (rdone),
        .o_Tx_DV     (txdv),
        .o_Tx_Byte   (txb),
        .i_Tx_Active (act),
        .i_Tx_Done   (done),
        .o_Busy      (busy),
        .o_Grant_Id  (gid),
        .o_Timeout   (tmo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    function automatic logic [31:0] pk(input logic [3:0] a, input logic [3:0] d, input logic v,
                                       input logic [7:0] b, input logic [1:0] g, input logic bz,
                                       input logic t);
        return {11'b0, a, d, v, b, g, bz, t};
    endfunction

    function automatic logic [31:0] obs();
        return pk(ack, rdone, txdv, txb, gid, busy, tmo);
    endfunction

    // Transaction-level reference: a transfer is either absent, just started,
    // or waiting for the transmitter; the grant goes to the first requester
    // after the last one served, counting modulo N.
    bit         mdl_on = 1'b0;
    int         m_last = -1;
    bit         m_fly  = 1'b0;
    bit         m_send = 1'b0;
    int         m_wait = 0;
    int         m_id   = 0;
    logic [7:0] m_byte = '0;
    logic [3:0] e_ack, e_done;
    logic       e_txdv, e_to;

    task automatic model_step();
        int k;
        bit found;
        e_ack  = '0;
        e_done = '0;
        e_txdv = 1'b0;
        e_to   = 1'b0;
        found  = 1'b0;
        if (rst) begin
            m_last = -1;
            m_fly  = 1'b0;
            m_send = 1'b0;
            m_wait = 0;
            m_id   = 0;
            m_byte = '0;
        end else if (!m_fly) begin
            if (dv != 0 && !act) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_last + 1 + i) % N;
                    if (!found && dv[k]) begin
                        found    = 1'b1;
                        m_last   = k;
                        m_id     = k;
                        m_byte   = bytes[8*k +: 8];
                        e_ack[k] = 1'b1;
                        e_txdv   = 1'b1;
                        m_fly    = 1'b1;
                        m_send   = 1'b1;
                    end
                end
            end
        end else if (m_send) begin
            m_send = 1'b0;
            m_wait = 0;
        end else if (done) begin
            e_done[m_id] = 1'b1;
            m_fly        = 1'b0;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (m_wait == TO) begin
            e_to  = 1'b1;
            m_fly = 1'b0;
        end else begin
            m_wait++;
        end
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (mdl_on) begin
            chk("rand_cycle", obs(), pk(e_ack, e_done, e_txdv, m_byte, 2'(m_id), m_fly, e_to));
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  dv;
        logic [31:0] bytes;
        logic        act;
        logic        done;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] d, input logic [31:0] b, input logic a,
                       input logic dn, input logic [3:0] x_ack, input logic [3:0] x_done,
                       input logic x_dv, input logic [7:0] x_byte, input logic [1:0] x_gid,
                       input logic x_busy);
        vec_t v;
        v.rst   = r;
        v.dv    = d;
        v.bytes = b;
        v.act   = a;
        v.done  = dn;
        v.exp   = pk(x_ack, x_done, x_dv, x_byte, x_gid, x_busy, 1'b0);
        tbl.push_back(v);
    endtask

    initial begin
        int cnt;
        logic [1:0] kk;
        logic [7:0] b;

        // Single request from requester 2; transmitter busy for 10 cycles.
        add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 2'd0, 0);
        add(0, 4'b0100, 32'h00A5_0000, 0, 0, 4'b0100, 4'b0000, 1, 8'hA5, 2'd2, 1);
        add(0, 4'b0000, 32'h00FF_0000, 1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 2'd2, 1);
        for (int i = 0; i < 9; i++)
            add(0, 4'b0000, 32'h00FF_0000, 1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 2'd2, 1);
        add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 4'b0100, 0, 8'hA5, 2'd2, 0);
        add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 4'b0000, 0, 8'hA5, 2'd2, 0);
        // Fairness: all four requesting, grants 0,1,2,3,0.
        add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 2'd0, 0);
        for (int k = 0; k < 5; k++) begin
            kk = 2'(k % 4);
            b  = 8'h10 + 8'(kk);
            add(0, 4'hF, 32'h1312_1110, 0, 0, 4'(1) << kk, 4'b0000, 1, b, kk, 1);
            add(0, 4'hF, 32'h1312_1110, 0, 0, 4'b0000, 4'b0000, 0, b, kk, 1);
            add(0, 4'hF, 32'h1312_1110, 0, 1, 4'b0000, 4'(1) << kk, 0, b, kk, 0);
        end
        // Wrap-around: after serving 3, requesters 0 and 3 compete; 0 wins.
        add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 2'd0, 0);
        add(0, 4'b1000, 32'hC300_0000, 0, 0, 4'b1000, 4'b0000, 1, 8'hC3, 2'd3, 1);
        add(0, 4'b0000, 32'hC300_0000, 0, 0, 4'b0000, 4'b0000, 0, 8'hC3, 2'd3, 1);
        add(0, 4'b0000, 32'hC300_0000, 0, 1, 4'b0000, 4'b1000, 0, 8'hC3, 2'd3, 0);
        add(0, 4'b1001, 32'hC300_00B7, 0, 0, 4'b0001, 4'b0000, 1, 8'hB7, 2'd0, 1);
        add(0, 4'b1001, 32'hC300_00B7, 0, 0, 4'b0000, 4'b0000, 0, 8'hB7, 2'd0, 1);
        add(0, 4'b1001, 32'hC300_00B7, 0, 1, 4'b0000, 4'b0001, 0, 8'hB7, 2'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst   = tbl[i].rst;
            dv    = tbl[i].dv;
            bytes = tbl[i].bytes;
            act   = tbl[i].act;
            done  = tbl[i].done;
            cyc();
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // Busy transmitter after reset: no grant for 50 cycles.
        rst = 1; dv = 0; act = 1; done = 0;
        cyc();
        chk("busy_reset", obs(), 32'h0);
        rst = 0; dv = 4'b0010; bytes = 32'h0000_5A00;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (txdv || busy) cnt++;
        end
        chk("busy_hold", 32'(cnt), 32'h0);
        act = 0;
        cyc();
        chk("busy_release", obs(), pk(4'b0010, 4'b0000, 1, 8'h5A, 2'd1, 1, 0));

        // Reset in the middle of WAIT.
        dv = 0;
        cyc();
        chk("rst_in_wait", {30'b0, busy, txdv}, 32'h2);
        act = 1;
        cyc();
        rst = 1;
        cyc();
        chk("rst_mid_wait", obs(), 32'h0);
        rst = 0; done = 1; act = 0;
        cyc();
        chk("rst_no_done", obs(), 32'h0);
        done = 0; act = 1; dv = 4'b0011; bytes = 32'h0000_7E3C;
        cyc();
        chk("rst_active_hold", obs(), 32'h0);
        act = 0;
        cyc();
        chk("rst_next_grant", obs(), pk(4'b0001, 4'b0000, 1, 8'h3C, 2'd0, 1, 0));
        dv = 0;
        cyc();
        done = 1;
        cyc();
        chk("rst_next_done", obs(), pk(4'b0000, 4'b0001, 0, 8'h3C, 2'd0, 0, 0));
        done = 0;

        // Transmitter that never reports completion.
        rst = 1;
        cyc();
        rst = 0; dv = 4'b0001; bytes = 32'h0000_00E1; act = 0;
        cyc();
        chk("to_grant", {27'b0, txdv, ack}, 32'h11);
        dv = 0;
        cyc();
        cnt = 0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int j = 1; j <= 17; j++) begin
            cyc();
            if (j < 17) begin
                if (!busy || tmo || rdone != 0) cnt++;
            end else begin
                chk("to_pulse", {26'b0, tmo, busy, rdone}, 32'h20);
            end
        end
        chk("to_wait_hold", 32'(cnt), 32'h0);
        cyc();
        chk("to_single", {31'b0, tmo}, 32'h0);
`else
        for (int j = 0; j < 40; j++) begin
            cyc();
            if (!busy || tmo) cnt++;
        end
        chk("wait_persist", 32'(cnt), 32'h0);
        done = 1;
        cyc();
        chk("wait_done", {27'b0, rdone, busy}, 32'h2);
        done = 0;
`endif

        // Randomized traffic against the reference model.
        rst = 1;
        cyc();
        rst = 0;
        mdl_on = 1'b1;
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            dv    = 4'($urandom) & 4'($urandom);
            bytes = $urandom;
            act   = ($urandom_range(0, 3) == 0);
            done  = ($urandom_range(0, 2) == 0);
            cyc();
        end
        mdl_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
